// File: rtl/riscv_pkg.sv
// Shared fetch-path types and constants: architectural widths, PC step and the
// {pc, instr} entry carried through the fetch buffer.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] PC_STEP   = 32'd4;
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ~32'd3;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: power-of-two ring of {pc, instr} entries with a registered head,
// synchronous flush and simultaneous push/pop at any occupancy.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           wdata,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  head_q, head_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          wr_en;

  assign wr_en = push & ~flush;

  // The head register is loaded with whatever entry will sit at the read
  // pointer after this cycle; the bypass covers a push into an emptying buffer.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
      if (push && (count_q == {{PW{1'b0}}, pop})) head_d = wdata;
      else                                        head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      if (wr_en) mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign head  = head_q;
  assign count = count_q;
  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, credit-based issue to a 1-cycle imem, redirect flush.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [ILEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            fetch_fault
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_CNT = (CW+1)'(FIFO_DEPTH);

  logic [XLEN-1:0] pc_fetch_q, pc_fetch_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic            inflight_q, inflight_d;
  logic            fault_hold;
  logic            pop, push, issue, credit_ok, full, empty;
  logic [CW-1:0]   count;
  logic [CW:0]     occ;
  fetch_entry_t    push_entry, head;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic fault_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                fault_q <= 1'b0;
    else if (redirect_valid) fault_q <= |redirect_pc[1:0];
  end

  assign fault_hold  = fault_q;
  assign fetch_fault = fault_q;
`else
  assign fault_hold  = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  assign pop  = instr_valid & instr_ready;
  assign push = inflight_q & ~redirect_valid;

  // Credits = buffered words plus the read in flight, net of this cycle's pop.
  // A full buffer can never coexist with an in-flight read, so only a pop frees it.
  assign occ       = {1'b0, count} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
  assign credit_ok = full ? (pop & ~inflight_q) : (occ < DEPTH_CNT);
  assign issue     = rst & ~redirect_valid & ~fault_hold & credit_ok;

  always_comb begin
    pc_fetch_d    = pc_fetch_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = 1'b0;
    if (redirect_valid) begin
      pc_fetch_d = align_pc(redirect_pc);
    end else if (issue) begin
      pc_fetch_d    = pc_fetch_q + PC_STEP;
      inflight_pc_d = pc_fetch_q;
      inflight_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_fetch_q    <= RESET_PC;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
    end else begin
      pc_fetch_q    <= pc_fetch_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
    end
  end

  assign push_entry = '{pc: inflight_pc_q, instr: imem_rdata};

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata (push_entry),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign imem_req    = issue;
  assign imem_addr   = pc_fetch_q;
  assign instr_valid = ~empty;
  assign instr       = head.instr;
  assign instr_pc    = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand sequences for redirect/fault/
// async reset, and a randomized run against an occupancy/stream reference model.
module tb_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        fetch_fault;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .fetch_fault    (fetch_fault)
  );

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0] ^ 16'h3C5A, ~a[15:0]};
  endfunction

  // Instruction memory: data for the address requested in the previous cycle.
  always @(posedge clk) imem_rdata <= imem_req ? word_of(imem_addr) : 32'hDEAD_0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic rdy, input logic rv, input logic [31:0] rpc);
    instr_ready    = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        e_valid;
    logic [31:0] e_pc;
    logic        e_req;
    logic [31:0] e_addr;
  } vec_t;

  function automatic vec_t mk(input logic rdy, input logic rv, input logic [31:0] rpc,
                              input logic ev, input logic [31:0] epc,
                              input logic erq, input logic [31:0] ea);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.e_valid = ev; v.e_pc = epc; v.e_req = erq; v.e_addr = ea;
    return v;
  endfunction

  vec_t tbl [32];

  // reference model state
  int          avail, pending, pop_m;
  logic        ereq, rdy_r, rv_r;
  logic [31:0] exp_pc, exp_fetch, tgt;

  initial begin
    // stall with two words held, resume, redirects, back-to-back redirect, wrap
    tbl[0]  = mk(0, 0, 0,            0, 0,            1, 32'h0);
    tbl[1]  = mk(0, 0, 0,            0, 0,            1, 32'h4);
    for (int i = 2; i < 12; i++)
      tbl[i] = mk(0, 0, 0,           1, 32'h0,        0, 32'h8);
    tbl[12] = mk(1, 0, 0,            1, 32'h0,        1, 32'h8);
    tbl[13] = mk(1, 0, 0,            1, 32'h4,        1, 32'hC);
    tbl[14] = mk(1, 0, 0,            1, 32'h8,        1, 32'h10);
    tbl[15] = mk(1, 0, 0,            1, 32'hC,        1, 32'h14);
    tbl[16] = mk(1, 1, 32'h100,      1, 32'h10,       0, 32'h0);
    tbl[17] = mk(1, 0, 0,            0, 0,            1, 32'h100);
    tbl[18] = mk(1, 0, 0,            0, 0,            1, 32'h104);
    tbl[19] = mk(1, 0, 0,            1, 32'h100,      1, 32'h108);
    tbl[20] = mk(1, 1, 32'h200,      1, 32'h104,      0, 32'h0);
    tbl[21] = mk(1, 1, 32'h300,      0, 0,            0, 32'h0);
    tbl[22] = mk(1, 0, 0,            0, 0,            1, 32'h300);
    tbl[23] = mk(1, 0, 0,            0, 0,            1, 32'h304);
    tbl[24] = mk(1, 0, 0,            1, 32'h300,      1, 32'h308);
    tbl[25] = mk(1, 0, 0,            1, 32'h304,      1, 32'h30C);
    tbl[26] = mk(1, 1, 32'hFFFF_FFF8, 1, 32'h308,     0, 32'h0);
    tbl[27] = mk(1, 0, 0,            0, 0,            1, 32'hFFFF_FFF8);
    tbl[28] = mk(1, 0, 0,            0, 0,            1, 32'hFFFF_FFFC);
    tbl[29] = mk(1, 0, 0,            1, 32'hFFFF_FFF8, 1, 32'h0);
    tbl[30] = mk(1, 0, 0,            1, 32'hFFFF_FFFC, 1, 32'h4);
    tbl[31] = mk(1, 0, 0,            1, 32'h0,        1, 32'h8);

    #12;
    chk("reset imem_req", imem_req, 0);
    chk("reset instr_valid", instr_valid, 0);
    chk("reset instr", instr, 0);
    chk("reset instr_pc", instr_pc, 0);
    chk("reset fetch_fault", fetch_fault, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    for (int i = 0; i < 32; i++) begin
      set_in(tbl[i].rdy, tbl[i].rv, tbl[i].rpc);
      chk($sformatf("tbl%0d instr_valid", i), instr_valid, tbl[i].e_valid);
      chk($sformatf("tbl%0d imem_req", i), imem_req, tbl[i].e_req);
      if (tbl[i].e_req) chk($sformatf("tbl%0d imem_addr", i), imem_addr, tbl[i].e_addr);
      if (tbl[i].e_valid) begin
        chk($sformatf("tbl%0d instr_pc", i), instr_pc, tbl[i].e_pc);
        chk($sformatf("tbl%0d instr", i), instr, word_of(tbl[i].e_pc));
      end
      next_cyc();
    end

    // misaligned redirect
    set_in(1, 1, 32'h102);
    chk("misalign redirect-cycle imem_req", imem_req, 0);
    next_cyc();
`ifdef FETCH_MISALIGN_TRAP_EN
    for (int i = 0; i < 4; i++) begin
      set_in(1, 0, 0);
      chk("fault fetch_fault", fetch_fault, 1);
      chk("fault imem_req", imem_req, 0);
      chk("fault instr_valid", instr_valid, 0);
      next_cyc();
    end
    set_in(1, 1, 32'h400);
    chk("fault clear-cycle fetch_fault", fetch_fault, 1);
    next_cyc();
    set_in(1, 0, 0);
    chk("fault cleared fetch_fault", fetch_fault, 0);
    chk("fault resume imem_req", imem_req, 1);
    chk("fault resume imem_addr", imem_addr, 32'h400);
    next_cyc();
    set_in(1, 0, 0);
    next_cyc();
    set_in(1, 0, 0);
    chk("fault resume instr_valid", instr_valid, 1);
    chk("fault resume instr_pc", instr_pc, 32'h400);
    chk("fault resume instr", instr, word_of(32'h400));
    next_cyc();
`else
    set_in(1, 0, 0);
    chk("misalign fetch_fault", fetch_fault, 0);
    chk("misalign imem_req", imem_req, 1);
    chk("misalign imem_addr", imem_addr, 32'h100);
    next_cyc();
    set_in(1, 0, 0);
    next_cyc();
    set_in(1, 0, 0);
    chk("misalign instr_valid", instr_valid, 1);
    chk("misalign instr_pc", instr_pc, 32'h100);
    next_cyc();
`endif

    // asynchronous reset between edges while streaming
    set_in(1, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    chk("async rst imem_req", imem_req, 0);
    chk("async rst instr_valid", instr_valid, 0);
    chk("async rst instr", instr, 0);
    chk("async rst instr_pc", instr_pc, 0);
    chk("async rst fetch_fault", fetch_fault, 0);
    next_cyc();
    rst = 1'b1;

    // randomized run against the reference model; restart must begin at RESET_PC
    avail = 0; pending = 0; exp_pc = 32'h0; exp_fetch = 32'h0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      rdy_r = (cyc < 200) ? 1'b1 : ($urandom_range(0, 9) < 7);
      rv_r  = (cyc >= 200) && ($urandom_range(0, 29) == 0);
      tgt   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 + 32'($urandom_range(0, 31)))
                                          : 32'($urandom_range(0, 4095));
`ifdef FETCH_MISALIGN_TRAP_EN
      tgt = tgt & ~32'd3;
`endif
      set_in(rdy_r, rv_r, tgt);
      pop_m = (avail > 0 && rdy_r) ? 1 : 0;
      ereq  = !rv_r && (avail + pending - pop_m < DEPTH);
      chk("rnd imem_req", imem_req, ereq);
      chk("rnd instr_valid", instr_valid, avail > 0);
      chk("rnd fetch_fault", fetch_fault, 0);
      if (ereq) chk("rnd imem_addr", imem_addr, exp_fetch);
      if (avail > 0) begin
        chk("rnd instr_pc", instr_pc, exp_pc);
        chk("rnd instr", instr, word_of(exp_pc));
      end
      next_cyc();
      if (rv_r) begin
        avail     = 0;
        pending   = 0;
        exp_pc    = tgt & ~32'd3;
        exp_fetch = tgt & ~32'd3;
      end else begin
        if (ereq) exp_fetch = exp_fetch + 32'd4;
        if (pop_m != 0) exp_pc = exp_pc + 32'd4;
        avail   = avail - pop_m + pending;
        pending = ereq ? 1 : 0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
